// File: rtl/fft_out_reorder.sv
// Reorders a bit-reversed FFT result stream into natural bin order using a
// two-bank ping-pong buffer: one frame is captured while the other drains.
module fft_out_reorder #(
    parameter int SAMPLE_WORD_LENGTH = 8,
    parameter int FFT_POINTS         = 16,
    parameter int BIT_REVERSED_IN    = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    input  logic                                 in_sof,
    input  logic signed [SAMPLE_WORD_LENGTH-1:0] in_i,
    input  logic signed [SAMPLE_WORD_LENGTH-1:0] in_q,
    output logic                                 in_ready,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [SAMPLE_WORD_LENGTH-1:0] out_i,
    output logic signed [SAMPLE_WORD_LENGTH-1:0] out_q,
    output logic [$clog2(FFT_POINTS)-1:0]        out_bin,
    output logic                                 out_sof,
    output logic                                 out_eof,
    output logic                                 ovf_err,
    output logic                                 frame_err,
    input  logic                                 err_clr
);

    localparam int                SWL      = SAMPLE_WORD_LENGTH;
    localparam int                LOG2N    = $clog2(FFT_POINTS);
    localparam logic [LOG2N-1:0]  LAST_IDX = LOG2N'(FFT_POINTS - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } rd_state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = v[LOG2N-1-b];
        end
        return r;
    endfunction

    // Storage is addressed {bank, natural bin}; never reset.
    logic [2*SWL-1:0] mem [2*FFT_POINTS];

    logic             w_bank;
    logic [LOG2N-1:0] w_cnt;
    logic [1:0]       full;
    logic [1:0]       full_nxt;

    logic             wr_acc;
    logic             wr_restart;
    logic             wr_last;
    logic [LOG2N-1:0] wr_idx;
    logic [LOG2N-1:0] wr_bin;

    rd_state_t        state_q;
    rd_state_t        state_d;
    logic             r_bank;
    logic             r_bank_d;
    logic [LOG2N-1:0] r_cnt;
    logic [LOG2N-1:0] r_cnt_d;
    logic             out_valid_d;
    logic             rd_load;
    logic             rd_release;
    logic             ld_bank;
    logic [LOG2N-1:0] ld_idx;
    logic [2*SWL-1:0] rd_word;

    // ---- write side: capture into the bank selected by w_bank ----
    assign in_ready   = !full[w_bank];
    assign wr_acc     = in_valid && in_ready;
    assign wr_restart = wr_acc && in_sof && (w_cnt != '0);
    assign wr_idx     = wr_restart ? '0 : w_cnt;
    assign wr_bin     = (BIT_REVERSED_IN != 0) ? bitrev(wr_idx) : wr_idx;
    assign wr_last    = wr_acc && !wr_restart && (w_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[{w_bank, wr_bin}] <= {in_i, in_q};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_bank <= 1'b0;
            w_cnt  <= '0;
        end else if (wr_acc) begin
            if (wr_restart) begin
                w_cnt <= LOG2N'(1);
            end else if (wr_last) begin
                w_cnt  <= '0;
                w_bank <= ~w_bank;
            end else begin
                w_cnt <= w_cnt + LOG2N'(1);
            end
        end
    end

    // Writer and reader always own different banks, so set and clear never collide.
    always_comb begin
        full_nxt = full;
        if (rd_release) begin
            full_nxt[r_bank] = 1'b0;
        end
        if (wr_last) begin
            full_nxt[w_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= '0;
        end else begin
            full <= full_nxt;
        end
    end

    // ---- read side: drain r_bank in natural order ----
    assign rd_word = mem[{ld_bank, ld_idx}];

    always_comb begin
        state_d     = state_q;
        r_bank_d    = r_bank;
        r_cnt_d     = r_cnt;
        out_valid_d = out_valid;
        rd_load     = 1'b0;
        rd_release  = 1'b0;
        ld_bank     = r_bank;
        ld_idx      = '0;
        case (state_q)
            IDLE: begin
                if (full[r_bank]) begin
                    rd_load     = 1'b1;
                    r_cnt_d     = '0;
                    out_valid_d = 1'b1;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (r_cnt != LAST_IDX) begin
                        rd_load = 1'b1;
                        ld_idx  = r_cnt + LOG2N'(1);
                        r_cnt_d = r_cnt + LOG2N'(1);
                    end else begin
                        rd_release = 1'b1;
                        r_bank_d   = ~r_bank;
                        r_cnt_d    = '0;
                        if (full[~r_bank]) begin
                            rd_load = 1'b1;
                            ld_bank = ~r_bank;
                        end else begin
                            out_valid_d = 1'b0;
                            state_d     = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            r_bank    <= 1'b0;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
            out_bin   <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_bank    <= r_bank_d;
            r_cnt     <= r_cnt_d;
            out_valid <= out_valid_d;
            if (rd_load) begin
                out_i   <= $signed(rd_word[2*SWL-1:SWL]);
                out_q   <= $signed(rd_word[SWL-1:0]);
                out_bin <= ld_idx;
                out_sof <= (ld_idx == '0);
                out_eof <= (ld_idx == LAST_IDX);
            end
        end
    end

    // ---- sticky error flags; clear wins over set ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err   <= 1'b0;
            frame_err <= 1'b0;
        end else if (err_clr) begin
            ovf_err   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                ovf_err <= 1'b1;
            end
            if (wr_restart) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: a frame-level model predicts natural-order
// output; a monitor process compares every output handshake against it.
module tb_fft_out_reorder;

    localparam int N = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_sof;
    logic signed [7:0] in_i;
    logic signed [7:0] in_q;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [7:0] out_i;
    logic signed [7:0] out_q;
    logic [3:0]        out_bin;
    logic              out_sof;
    logic              out_eof;
    logic              ovf_err;
    logic              frame_err;
    logic              err_clr;

    fft_out_reorder #(
        .SAMPLE_WORD_LENGTH(8),
        .FFT_POINTS        (N),
        .BIT_REVERSED_IN   (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_i     (in_i),
        .in_q     (in_q),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_i    (out_i),
        .out_q    (out_q),
        .out_bin  (out_bin),
        .out_sof  (out_sof),
        .out_eof  (out_eof),
        .ovf_err  (ovf_err),
        .frame_err(frame_err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] i;
        logic [7:0] q;
        logic [3:0] bin;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] part_i[$];
    logic [7:0] part_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;         // 0: always ready, 1: never ready, 2: random
    int last_acc_cyc = 0;
    int rise_cyc = -1;
    int last_eof_cyc = -1;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, expv, expv, cyc);
        end
    endtask

    function automatic int bitrev4(input int v);
        int r = 0;
        for (int b = 0; b < 4; b++) begin
            if (v & (1 << b)) r |= 1 << (3 - b);
        end
        return r;
    endfunction

    // Frame model: capture index k lands at bin bitrev(k); a full frame is
    // then read out as bins 0..N-1.
    task automatic model_accept(input logic [7:0] i, input logic [7:0] q, input logic sof);
        exp_t e;
        if (sof && part_i.size() != 0) begin
            part_i.delete();
            part_q.delete();
        end
        part_i.push_back(i);
        part_q.push_back(q);
        if (part_i.size() == N) begin
            for (int b = 0; b < N; b++) begin
                e.i   = part_i[bitrev4(b)];
                e.q   = part_q[bitrev4(b)];
                e.bin = 4'(b);
                exp_q.push_back(e);
            end
            part_i.delete();
            part_q.delete();
        end
    endtask

    // Monitor: a handshake seen at a falling edge completes on the next rising edge.
    logic       hold_pend = 1'b0;
    logic       prev_v = 1'b0;
    logic [21:0] held;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            hold_pend = 1'b0;
            prev_v    = 1'b0;
        end else begin
            if (out_valid && !prev_v) rise_cyc = cyc;
            prev_v = out_valid;
            if (hold_pend) begin
                check("stall_valid_held", int'(out_valid), 1);
                check("stall_data_held", int'({out_i, out_q, out_bin, out_sof, out_eof}), int'(held));
            end
            hold_pend = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output_bin", int'(out_bin), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_iq", int'({out_i, out_q}), int'({e.i, e.q}));
                        check("out_bin", int'(out_bin), int'(e.bin));
                        check("out_sof_eof", int'({out_sof, out_eof}),
                              int'({e.bin == 4'd0, e.bin == 4'd15}));
                    end
                    if (out_eof) last_eof_cyc = cyc;
                end else begin
                    hold_pend = 1'b1;
                    held      = {out_i, out_q, out_bin, out_sof, out_eof};
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] i, input logic [7:0] q, input logic sof);
        int t = 0;
        in_valid = 1'b1;
        in_i     = i;
        in_q     = q;
        in_sof   = sof;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(i, q, sof);
                last_acc_cyc = cyc;
                break;
            end
            t++;
            if (t > 500) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int mode, input int gaps);
        logic [7:0] a;
        logic [7:0] b;
        for (int k = 0; k < N; k++) begin
            if (mode == 0) begin
                a = 8'(k);
                b = 8'(-k);
            end else begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            if (gaps != 0 && $urandom_range(0, 3) == 0) idle(1);
            send(a, b, k == 0);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_remaining", exp_q.size(), 0);
    endtask

    task automatic drop_one(input logic clr);
        in_valid = 1'b1;
        in_sof   = 1'b0;
        err_clr  = clr;
        @(negedge clk);
        check("drop_in_ready_low", int'(in_ready), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    initial begin
        int t;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_i     = '0;
        in_q     = '0;
        err_clr  = 1'b0;
        idle(3);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'({out_i, out_q, out_bin, out_sof, out_eof}), 0);
        check("rst_err_flags", int'({ovf_err, frame_err}), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // Single ramp frame, always ready; first valid two edges after last accept.
        rdy_mode = 0;
        idle(1);
        send_frame(0, 0);
        drain();
        check("first_valid_latency", rise_cyc - last_acc_cyc, 2);

        // Three back-to-back random frames.
        for (int f = 0; f < 3; f++) send_frame(1, 0);
        drain();

        // Downstream stalled: two frames fill both banks, then overflow.
        rdy_mode = 1;
        idle(1);
        send_frame(1, 0);
        send_frame(1, 0);
        @(negedge clk);
        check("both_full_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        drop_one(1'b1);
        @(negedge clk);
        check("ovf_clr_priority", int'(ovf_err), 0);
        @(posedge clk);
        #1;
        drop_one(1'b0);
        @(negedge clk);
        check("ovf_err_set", int'(ovf_err), 1);
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        @(negedge clk);
        check("ovf_err_cleared", int'(ovf_err), 0);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        check("in_ready_after_release", cyc - last_eof_cyc, 1);
        @(posedge clk);
        #1;
        drain();

        // Random backpressure with input gaps.
        rdy_mode = 2;
        for (int f = 0; f < 4; f++) send_frame(1, 1);
        drain();

        // Early in_sof after five samples restarts the frame.
        rdy_mode = 0;
        for (int k = 0; k < 5; k++) send(8'($urandom), 8'($urandom), k == 0);
        @(negedge clk);
        check("frame_err_before", int'(frame_err), 0);
        @(posedge clk);
        #1;
        send_frame(1, 0);
        @(negedge clk);
        check("frame_err_set", int'(frame_err), 1);
        @(posedge clk);
        #1;
        drain();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        @(negedge clk);
        check("frame_err_cleared", int'(frame_err), 0);
        @(posedge clk);
        #1;

        // Asynchronous reset while bin 7 is on the output.
        send_frame(1, 0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(out_valid && out_bin == 4'd7) && t < 200);
        check("reached_bin7", int'(out_bin), 7);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_out_valid", int'(out_valid), 0);
        check("async_rst_out_data", int'({out_i, out_q, out_bin, out_sof, out_eof}), 0);
        check("async_rst_in_ready", int'(in_ready), 1);
        exp_q.delete();
        part_i.delete();
        part_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(4);
        @(negedge clk);
        check("no_residual_output", int'(out_valid), 0);
        @(posedge clk);
        #1;
        send_frame(1, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
